// File: rtl/parity_pkg.sv
// Shared types and default sizes for the parity checker.
package parity_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_TAG_WIDTH = 4;
    localparam int DEF_CNT_WIDTH = 8;

    // Error alert states: ALERT holds the first error, OVF flags a later one.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALERT = 2'd1,
        ST_OVF   = 2'd2
    } alert_state_e;

endpackage

// File: rtl/parity_check_if.sv
// Stream, counter and alert signals between the parity checker and its user.
interface parity_check_if #(
    parameter int WIDTH     = parity_pkg::DEF_WIDTH,
    parameter int TAG_WIDTH = parity_pkg::DEF_TAG_WIDTH,
    parameter int CNT_WIDTH = parity_pkg::DEF_CNT_WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_parity;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_err;
    logic [CNT_WIDTH-1:0] err_count;
    logic                 cnt_clear;
    logic                 err_irq;
    logic                 err_ovf;
    logic [TAG_WIDTH-1:0] err_tag;
    logic                 err_ack;

    // Producer/consumer side that drives words in and acknowledges alerts.
    modport master (
        output in_valid, in_data, in_parity, in_tag, out_ready, cnt_clear, err_ack,
        input  in_ready, out_valid, out_data, out_err, err_count, err_irq, err_ovf, err_tag
    );

    // Checker side.
    modport slave (
        input  in_valid, in_data, in_parity, in_tag, out_ready, cnt_clear, err_ack,
        output in_ready, out_valid, out_data, out_err, err_count, err_irq, err_ovf, err_tag
    );
endinterface

// File: rtl/parity.sv
// Parity generator: XOR reduction of the data word (even parity bit).
module parity #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             par
);
    assign par = ^data;
endmodule

// File: rtl/parity_check.sv
// Parity checker with one output register stage, saturating error counter
// and a sticky alert FSM that records the tag of the first error.
module parity_check #(
    parameter int WIDTH     = parity_pkg::DEF_WIDTH,
    parameter int TAG_WIDTH = parity_pkg::DEF_TAG_WIDTH,
    parameter int CNT_WIDTH = parity_pkg::DEF_CNT_WIDTH,
    parameter int ODD       = 0
) (
    input  logic           clk,
    input  logic           reset,
    parity_check_if.slave  bus
);
    import parity_pkg::*;

    localparam logic                 ODD_BIT = (ODD != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic                 out_err_q,   out_err_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [TAG_WIDTH-1:0] err_tag_q,   err_tag_d;
    alert_state_e         state_q,     state_d;

    logic calc_par;
    logic word_err;
    logic accept;
    logic accept_err;

    parity #(.WIDTH(WIDTH)) u_parity (
        .data (bus.in_data),
        .par  (calc_par)
    );

    // Handshake: the output register may be refilled while it drains.
    always_comb begin
        bus.in_ready = !out_valid_q || bus.out_ready;
        accept       = bus.in_valid && bus.in_ready;
        word_err     = calc_par ^ bus.in_parity ^ ODD_BIT;
        accept_err   = accept && word_err;
    end

    // Output register: load on accept, empty on drain, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data;
            out_err_d   = word_err;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Saturating error counter; a clear still counts a coincident error.
    always_comb begin
        err_count_d = err_count_q;
        if (bus.cnt_clear) begin
            err_count_d = accept_err ? CNT_ONE : '0;
        end else if (accept_err && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_ONE;
        end
    end

    // Alert FSM next state; the tag is only replaced when entering ALERT.
    always_comb begin
        state_d   = state_q;
        err_tag_d = err_tag_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_err) begin
                    state_d   = ST_ALERT;
                    err_tag_d = bus.in_tag;
                end
            end
            ST_ALERT, ST_OVF: begin
                if (bus.err_ack) begin
                    if (accept_err) begin
                        state_d   = ST_ALERT;
                        err_tag_d = bus.in_tag;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept_err) begin
                    state_d = ST_OVF;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset wins over any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
            err_tag_q   <= '0;
            state_q     <= ST_IDLE;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
            err_tag_q   <= err_tag_d;
            state_q     <= state_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.err_count = err_count_q;
    assign bus.err_tag   = err_tag_q;
    assign bus.err_irq   = (state_q != ST_IDLE);
    assign bus.err_ovf   = (state_q == ST_OVF);

endmodule

// File: tb/tb_parity_check.sv
// Directed bench for parity_check: table of words plus hand-written
// backpressure, reset and counter saturation sequences.
module tb_parity_check;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    parity_check_if #(.WIDTH(8), .TAG_WIDTH(4), .CNT_WIDTH(8)) ifa ();
    parity_check_if #(.WIDTH(8), .TAG_WIDTH(4), .CNT_WIDTH(2)) ifb ();

    parity_check #(.WIDTH(8), .TAG_WIDTH(4), .CNT_WIDTH(8), .ODD(0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    parity_check #(.WIDTH(8), .TAG_WIDTH(4), .CNT_WIDTH(2), .ODD(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic [3:0] tag;
        logic       ack;
        logic       exp_err;
        logic [7:0] exp_cnt;
        logic       exp_irq;
        logic       exp_ovf;
        logic [3:0] exp_tag;
    } vec_t;

    vec_t vecs [10];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // data, par, tag, ack | err, cnt, irq, ovf, tag
        vecs[0] = '{8'h5A, 1'b0, 4'h1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'h0};
        vecs[1] = '{8'h01, 1'b1, 4'h1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'h0};
        vecs[2] = '{8'h03, 1'b1, 4'h7, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 4'h7};
        vecs[3] = '{8'hFF, 1'b0, 4'h3, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 4'h7};
        vecs[4] = '{8'h80, 1'b0, 4'h2, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 4'h2};
        vecs[5] = '{8'h07, 1'b0, 4'h5, 1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 4'h2};
        vecs[6] = '{8'h00, 1'b1, 4'h9, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 4'h9};
        vecs[7] = '{8'h0F, 1'b0, 4'h4, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 4'h9};
        vecs[8] = '{8'hAA, 1'b0, 4'h0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b0, 4'h9};
        vecs[9] = '{8'h00, 1'b0, 4'h6, 1'b1, 1'b0, 8'd4, 1'b0, 1'b0, 4'h9};

        reset = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_parity = 1'b0; ifa.in_tag = '0;
        ifa.out_ready = 1'b1; ifa.cnt_clear = 1'b0; ifa.err_ack = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_parity = 1'b0; ifb.in_tag = '0;
        ifb.out_ready = 1'b1; ifb.cnt_clear = 1'b0; ifb.err_ack = 1'b0;

        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_out_data",  ifa.out_data, 0);
        chk("rst_out_err",   ifa.out_err, 0);
        chk("rst_err_count", ifa.err_count, 0);
        chk("rst_err_irq",   ifa.err_irq, 0);
        chk("rst_err_ovf",   ifa.err_ovf, 0);
        chk("rst_err_tag",   ifa.err_tag, 0);
        chk("rst_in_ready",  ifa.in_ready, 1);
        chk("rst_b_count",   ifb.err_count, 0);

        // Table: one word per cycle with out_ready held high
        for (int i = 0; i < 10; i++) begin
            ifa.in_valid  = 1'b1;
            ifa.in_data   = vecs[i].data;
            ifa.in_parity = vecs[i].par;
            ifa.in_tag    = vecs[i].tag;
            ifa.err_ack   = vecs[i].ack;
            tick();
            chk($sformatf("v%0d_out_valid", i), ifa.out_valid, 1);
            chk($sformatf("v%0d_out_data", i),  ifa.out_data, vecs[i].data);
            chk($sformatf("v%0d_out_err", i),   ifa.out_err, vecs[i].exp_err);
            chk($sformatf("v%0d_err_count", i), ifa.err_count, vecs[i].exp_cnt);
            chk($sformatf("v%0d_err_irq", i),   ifa.err_irq, vecs[i].exp_irq);
            chk($sformatf("v%0d_err_ovf", i),   ifa.err_ovf, vecs[i].exp_ovf);
            chk($sformatf("v%0d_err_tag", i),   ifa.err_tag, vecs[i].exp_tag);
        end
        ifa.in_valid = 1'b0;
        ifa.err_ack  = 1'b0;
        tick();
        chk("drain_out_valid", ifa.out_valid, 0);

        // Backpressure: one word accepted, then stalled for 3 cycles
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_data   = 8'h3C;
        ifa.in_parity = 1'b0;
        ifa.in_tag    = 4'h0;
        tick();
        chk("bp_first_valid", ifa.out_valid, 1);
        ifa.in_data = 8'h11;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp%0d_in_ready", k), ifa.in_ready, 0);
            tick();
            chk($sformatf("bp%0d_out_valid", k), ifa.out_valid, 1);
            chk($sformatf("bp%0d_out_data", k),  ifa.out_data, 8'h3C);
            chk($sformatf("bp%0d_out_err", k),   ifa.out_err, 0);
        end
        ifa.out_ready = 1'b1;
        tick();
        chk("b2b_out_valid", ifa.out_valid, 1);
        chk("b2b_out_data",  ifa.out_data, 8'h11);
        ifa.in_valid = 1'b0;
        tick();
        chk("bp_end_valid", ifa.out_valid, 0);
        chk("bp_err_count", ifa.err_count, 4);

        // Reset mid-operation while in OVF with a stalled output word
        ifa.in_valid  = 1'b1;
        ifa.in_data   = 8'h80;
        ifa.in_parity = 1'b0;
        ifa.in_tag    = 4'h2;
        tick();
        ifa.in_data = 8'h07;
        ifa.in_tag  = 4'h5;
        tick();
        chk("pre_rst_ovf",   ifa.err_ovf, 1);
        chk("pre_rst_tag",   ifa.err_tag, 4'h2);
        chk("pre_rst_count", ifa.err_count, 6);
        ifa.out_ready = 1'b0;
        ifa.in_data   = 8'h01;
        ifa.in_tag    = 4'hC;
        reset = 1'b1;
        tick();
        chk("mid_rst_out_valid", ifa.out_valid, 0);
        chk("mid_rst_out_data",  ifa.out_data, 0);
        chk("mid_rst_out_err",   ifa.out_err, 0);
        chk("mid_rst_err_count", ifa.err_count, 0);
        chk("mid_rst_err_irq",   ifa.err_irq, 0);
        chk("mid_rst_err_ovf",   ifa.err_ovf, 0);
        chk("mid_rst_err_tag",   ifa.err_tag, 0);
        chk("mid_rst_in_ready",  ifa.in_ready, 1);
        reset = 1'b0;
        ifa.in_valid = 1'b0;
        tick();
        chk("post_rst_count", ifa.err_count, 0);
        chk("post_rst_valid", ifa.out_valid, 0);

        // Counter saturation on the 2-bit instance, then clear with an error
        ifb.in_valid  = 1'b1;
        ifb.in_data   = 8'h01;
        ifb.in_parity = 1'b0;
        ifb.in_tag    = 4'h1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("sat%0d_count", k), ifb.err_count, (k < 3) ? k + 1 : 3);
        end
        ifb.cnt_clear = 1'b1;
        tick();
        chk("clr_err_count", ifb.err_count, 1);
        ifb.in_valid = 1'b0;
        tick();
        chk("clr_only_count", ifb.err_count, 0);
        ifb.cnt_clear = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_check.md
PARITY_CHECK -- requirements
Module: parity_check

Interface
REQ-001 SHALL have parameter WIDTH, default 8: protected data width in bits.
REQ-002 SHALL have parameter TAG_WIDTH, default 4: width of the per-word identifier.
REQ-003 SHALL have parameter CNT_WIDTH, default 8: width of the error counter.
REQ-004 SHALL have parameter ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-006 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: input word is present.
REQ-008 SHALL have port in_ready, output, 1 bit: the checker accepts the word this cycle.
REQ-009 SHALL have port in_data, input, WIDTH bits: stored data word.
REQ-010 SHALL have port in_parity, input, 1 bit: stored parity bit for in_data.
REQ-011 SHALL have port in_tag, input, TAG_WIDTH bits: word identifier (address or entry index).
REQ-012 SHALL have port out_valid, output, 1 bit: checked word is present.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the output.
REQ-014 SHALL have port out_data, output, WIDTH bits: data passed through unmodified.
REQ-015 SHALL have port out_err, output, 1 bit: parity mismatch on out_data.
REQ-016 SHALL have port err_count, output, CNT_WIDTH bits: saturating count of erroneous words.
REQ-017 SHALL have port cnt_clear, input, 1 bit: synchronous clear of err_count.
REQ-018 SHALL have port err_irq, output, 1 bit: error alert, held until acknowledged.
REQ-019 SHALL have port err_ovf, output, 1 bit: a further error arrived while the alert was pending.
REQ-020 SHALL have port err_tag, output, TAG_WIDTH bits: in_tag of the first unacknowledged error.
REQ-021 SHALL have port err_ack, input, 1 bit: acknowledges the alert.

Function
REQ-022 SHALL accept a word when in_valid && in_ready, with in_ready = !out_valid || out_ready (single output register stage).
REQ-023 SHALL present an accepted word on out_* exactly 1 cycle after acceptance; out_data equals in_data.
REQ-024 SHALL compute out_err = (XOR of in_data bits) ^ in_parity ^ ODD at acceptance.
REQ-025 SHALL hold out_valid, out_data and out_err stable while out_valid && !out_ready.
REQ-026 SHALL clear out_valid on an output handshake with no new acceptance; back-to-back accept and drain in one cycle SHALL keep out_valid at 1.
REQ-027 SHALL increment err_count by 1 per accepted erroneous word, saturating at 2^CNT_WIDTH-1.
REQ-028 SHALL load err_count with 1 when cnt_clear coincides with an accepted error, and with 0 otherwise on cnt_clear.
REQ-029 SHALL implement an alert FSM with states IDLE, ALERT and OVF; err_irq = (state != IDLE) and err_ovf = (state == OVF).
REQ-030 SHALL transition IDLE->ALERT on an accepted error and capture in_tag into err_tag.
REQ-031 SHALL transition ALERT->OVF on an accepted error without err_ack; err_tag SHALL be unchanged.
REQ-032 SHALL transition ALERT or OVF->IDLE on err_ack with no accepted error.
REQ-033 SHALL transition ALERT or OVF->ALERT on err_ack with an accepted error in the same cycle, and capture the new in_tag.
REQ-034 SHALL ignore err_ack in IDLE.
REQ-035 SHALL base every error event (counter and FSM) on acceptance, never on output handshake.

Reset
REQ-036 SHALL, on reset, set out_valid=0, out_err=0, out_data=0, err_count=0, err_tag=0, and FSM=IDLE (err_irq=0, err_ovf=0).
REQ-037 SHALL give reset priority over all inputs; a word in flight at reset SHALL be discarded, not counted.
REQ-038 SHALL drive in_ready=1 during the cycle following reset.

Structure
REQ-039 SHALL place the FSM state enum and the default WIDTH/TAG_WIDTH/CNT_WIDTH constants in a shared package parity_pkg.
REQ-040 SHALL recompute parity with one instance of the existing parity generator module (parity, WIDTH passed through).

Verification
REQ-041 SHALL verify clean stream: WIDTH=8, data 0x5A with parity 0 followed by 0x01 with parity 1, out_ready=1 -> outputs 1 cycle later, out_err=0, err_count=0, err_irq=0.
REQ-042 SHALL verify single error: data 0x03 with parity 1, tag 0x7 -> out_err=1, err_count=1, err_irq=1, err_tag=0x7; err_ack -> IDLE next cycle.
REQ-043 SHALL verify backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable, exactly one word accepted.
REQ-044 SHALL verify overflow and coincident ack: errors at tags 2 then 5 without ack -> err_ovf=1, err_tag=2; then ack plus error at tag 9 -> ALERT, err_tag=9, err_ovf=0.
REQ-045 SHALL verify saturation and clear: CNT_WIDTH=2 with 5 errors -> err_count=3; cnt_clear with an error in the same cycle -> 1.
REQ-046 SHALL verify reset mid-operation: reset while out_valid=1 and state OVF -> all outputs at reset values next cycle, and in_ready=1.
